// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state, opcode, funct, ALU and mux-select encodings for mc_ctrl
package mc_ctrl_pkg;

    localparam logic [3:0] S_INIT     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_ALU_WB   = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WB   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_OR,
        ALU_CLS_SUB,
        ALU_CLS_R
    } alu_class_t;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic r_ok;
        r_ok = (funct == FN_ADDU) || (funct == FN_SUBU) || (funct == FN_SLTU);
        return ((op == OP_RTYPE) && r_ok) || (op == OP_ORI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_alu_ctr_dec.sv
// rtl/mc_ctrl_alu_ctr_dec.sv - maps operation class and funct to the 3-bit ALU code
module alu_ctr_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  funct,
    input  alu_class_t  cls,
    output logic [2:0]  alu_ctr
);

    always_comb begin
        alu_ctr = ALU_ADD;
        case (cls)
            ALU_CLS_OR:  alu_ctr = ALU_OR;
            ALU_CLS_SUB: alu_ctr = ALU_SUB;
            ALU_CLS_R: begin
                case (funct)
                    FN_SUBU: alu_ctr = ALU_SUB;
                    FN_SLTU: alu_ctr = ALU_SLTU;
                    default: alu_ctr = ALU_ADD;
                endcase
            end
            default: alu_ctr = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM driving datapath strobes and ALU code
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctr,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] next_state;
    alu_class_t alu_cls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= next_state;
        end
    end

    assign state = state_q;

    // Non-ALU states leave the class at ADD, which decodes to the all-zero default code.
    alu_ctr_dec u_alu_ctr_dec (
        .funct   (funct),
        .cls     (alu_cls),
        .alu_ctr (alu_ctr)
    );

    always_comb begin
        next_state = state_q;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        ext_op     = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_cls    = ALU_CLS_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_INIT: next_state = S_FETCH;
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_wr     = mem_ready;
                ir_wr     = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                ext_op    = 1'b1;
                // An unsupported instruction retires here; PC was already advanced in FETCH.
                if (!is_legal(op, funct)) begin
                    illegal    = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    case (op)
                        OP_RTYPE: next_state = S_EXEC_R;
                        OP_ORI:   next_state = S_EXEC_I;
                        OP_BEQ:   next_state = S_BRANCH;
                        OP_J:     next_state = S_JUMP;
                        default:  next_state = S_MEM_ADDR;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RT;
                alu_cls    = ALU_CLS_R;
                next_state = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_cls    = ALU_CLS_OR;
                next_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = (op == OP_RTYPE);
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                ext_op     = 1'b1;
                next_state = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                if (mem_ready) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RT;
                alu_cls    = ALU_CLS_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_wr      = zero;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_wr      = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized self-checking bench for mc_ctrl against a per-instruction model
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       ext_op, illegal;
    logic [2:0] alu_ctr;
    logic [3:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int P_INIT = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC_R = 3, P_EXEC_I = 4,
                   P_ALU_WB = 5, P_MEM_ADDR = 6, P_MEM_RD = 7, P_MEM_WB = 8,
                   P_MEM_WR = 9, P_BRANCH = 10, P_JUMP = 11;

    string ph_name [12] = '{"init", "fetch", "decode", "exec_r", "exec_i", "alu_wb",
                            "mem_addr", "mem_rd", "mem_wb", "mem_wr", "branch", "jump"};

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_wr      (pc_wr),
        .ir_wr      (ir_wr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_op     (ext_op),
        .pc_src     (pc_src),
        .alu_ctr    (alu_ctr),
        .illegal    (illegal),
        .state      (state)
    );

    wire [20:0] obs = {pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg, alu_src_a,
                       alu_src_b, ext_op, pc_src, alu_ctr, illegal, state};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (op=%h funct=%h)", tag, got, exp, op, funct);
        end
    endtask

    function automatic bit legal_instr(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) return (f == 6'h21) || (f == 6'h23) || (f == 6'h2B);
        return (o == 6'h0D) || (o == 6'h23) || (o == 6'h2B) || (o == 6'h04) || (o == 6'h02);
    endfunction

    // Expected outputs for one cycle of an instruction step, straight from the control table.
    function automatic logic [20:0] exp_out(input int ph, input logic [5:0] o, input logic [5:0] f,
                                            input bit zr, input bit rdy);
        bit pw = 0, iw = 0, mr = 0, mw = 0, rw = 0, rd = 0, m2r = 0, sa = 0, ex = 0, il = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] ac = 3'b000;
        case (ph)
            P_FETCH:    begin mr = 1; sb = 2'b01; pw = rdy; iw = rdy; end
            P_DECODE:   begin sb = 2'b11; ex = 1; il = !legal_instr(o, f); end
            P_EXEC_R:   begin sa = 1; ac = (f == 6'h23) ? 3'b100 : (f == 6'h2B) ? 3'b110 : 3'b000; end
            P_EXEC_I:   begin sa = 1; sb = 2'b10; ac = 3'b010; end
            P_ALU_WB:   begin rw = 1; rd = (o == 6'h00); end
            P_MEM_ADDR: begin sa = 1; sb = 2'b10; ex = 1; end
            P_MEM_RD:   mr = 1;
            P_MEM_WB:   begin rw = 1; m2r = 1; end
            P_MEM_WR:   mw = 1;
            P_BRANCH:   begin sa = 1; ac = 3'b100; ps = 2'b01; pw = zr; end
            P_JUMP:     begin ps = 2'b10; pw = 1; end
            default:    ;
        endcase
        return {pw, iw, mr, mw, rw, rd, m2r, sa, sb, ex, ps, ac, il, 4'(ph)};
    endfunction

    task automatic step(input int ph, input bit rdy, input bit zr);
        mem_ready = rdy;
        zero = zr;
        @(negedge clk);
        check_val(ph_name[ph], {11'd0, obs}, {11'd0, exp_out(ph, op, funct, zr, rdy)});
        @(posedge clk);
        #1;
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input bit zr,
                             input int stall_f, input int stall_m);
        op = o;
        funct = f;
        for (int i = 0; i < stall_f; i++) step(P_FETCH, 0, rb());
        step(P_FETCH, 1, rb());
        step(P_DECODE, rb(), rb());
        if (legal_instr(o, f)) begin
            case (o)
                6'h00: begin step(P_EXEC_R, rb(), rb()); step(P_ALU_WB, rb(), rb()); end
                6'h0D: begin step(P_EXEC_I, rb(), rb()); step(P_ALU_WB, rb(), rb()); end
                6'h23: begin
                    step(P_MEM_ADDR, rb(), rb());
                    for (int i = 0; i < stall_m; i++) step(P_MEM_RD, 0, rb());
                    step(P_MEM_RD, 1, rb());
                    step(P_MEM_WB, rb(), rb());
                end
                6'h2B: begin
                    step(P_MEM_ADDR, rb(), rb());
                    for (int i = 0; i < stall_m; i++) step(P_MEM_WR, 0, rb());
                    step(P_MEM_WR, 1, rb());
                end
                6'h04: step(P_BRANCH, rb(), zr);
                default: step(P_JUMP, rb(), rb());
            endcase
        end
    endtask

    logic [5:0] op_pool [8] = '{6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F, 6'h08};
    logic [5:0] fn_pool [4] = '{6'h21, 6'h23, 6'h2B, 6'h20};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(P_INIT, rb(), rb());

        run_instr(6'h00, 6'h21, 0, 0, 0);
        run_instr(6'h00, 6'h23, 0, 0, 0);
        run_instr(6'h00, 6'h2B, 0, 0, 0);
        run_instr(6'h23, 6'h00, 0, 0, 3);
        run_instr(6'h04, 6'h00, 1, 0, 0);
        run_instr(6'h04, 6'h00, 0, 0, 0);
        run_instr(6'h0D, 6'h11, 0, 0, 0);
        run_instr(6'h02, 6'h00, 0, 0, 0);
        run_instr(6'h3F, 6'h00, 0, 0, 0);
        run_instr(6'h00, 6'h20, 0, 0, 0);
        run_instr(6'h2B, 6'h00, 0, 2, 1);

        // Reset asserted mid-cycle while the FSM waits in MEM_RD.
        op = 6'h23;
        funct = 6'h00;
        step(P_FETCH, 1, 0);
        step(P_DECODE, 1, 0);
        step(P_MEM_ADDR, 1, 0);
        step(P_MEM_RD, 0, 0);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("reset_async", {11'd0, obs}, 32'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        check_val("reset_hold", {11'd0, obs}, 32'd0);
        rst_n = 1'b1;
        step(P_INIT, 1, rb());

        for (int n = 0; n < 60; n++) begin
            logic [5:0] o, f;
            o = op_pool[$urandom_range(0, 7)];
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) == 0) o = 6'($urandom);
            run_instr(o, f, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        end
        step(P_FETCH, 0, rb());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
